// File: rtl/d_cond_unit_pkg.sv
// Shared definitions for the decode-stage condition unit: op encodings,
// FSM state encoding and the chunk-count helper.
package d_cond_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_EQ       = 3'd0;
  localparam logic [OP_W-1:0] OP_NE       = 3'd1;
  localparam logic [OP_W-1:0] OP_LEZ      = 3'd2;
  localparam logic [OP_W-1:0] OP_GTZ      = 3'd3;
  localparam logic [OP_W-1:0] OP_LTZ      = 3'd4;
  localparam logic [OP_W-1:0] OP_GEZ      = 3'd5;
  localparam logic [OP_W-1:0] OP_POP_EVEN = 3'd6;
  localparam logic [OP_W-1:0] OP_POP_GE   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of count cycles needed to walk an operand chunk by chunk.
  function automatic int n_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/d_cond_unit_if.sv
// Request/result bundle between the D stage and the condition unit.
interface d_cond_unit_if
  import d_cond_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [CNT_W-1:0] thresh;
  logic             flush;
  logic             busy;
  logic             done;
  logic             cond;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output start, op, rs_val, rt_val, thresh, flush,
    input  busy, done, cond, cnt_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, thresh, flush,
    output busy, done, cond, cnt_out
  );
endinterface

// File: rtl/d_cond_unit_popcnt_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcnt_chunk #(
  parameter int CHUNK = 8,
  parameter int OUT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [OUT_W-1:0] count
);

  // Sum the set bits of the slice.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/d_cond_unit.sv
// Decode-stage condition unit. Sign/equality compares resolve in one cycle;
// popcount conditions walk the latched operand CHUNK bits per cycle while
// busy stalls the D stage, then pulse done with the result.
module d_cond_unit
  import d_cond_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  d_cond_unit_if.slave bus
);

  localparam int N     = n_chunks(WIDTH, CHUNK);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PC_W  = $clog2(CHUNK + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic             cond_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] acc;
  logic [IDX_W-1:0] idx;

  // Operands captured at acceptance; popcount ops read only these.
  logic [OP_W-1:0]  op_p0;
  logic [WIDTH-1:0] rs_p0;
  logic [CNT_W-1:0] thresh_p0;

  logic             accept;
  logic [CHUNK-1:0] chunk_bits;
  logic [PC_W-1:0]  chunk_cnt;
  logic [CNT_W-1:0] acc_next;
  logic             pop_cond;

  function automatic logic is_pop(input logic [OP_W-1:0] o);
    return (o == OP_POP_EVEN) || (o == OP_POP_GE);
  endfunction

  // Single-cycle compares; sign ops look only at the MSB plus a zero test.
  function automatic logic cmp_eval(input logic [OP_W-1:0]  o,
                                    input logic [WIDTH-1:0] rs,
                                    input logic [WIDTH-1:0] rt);
    logic neg;
    logic zero;
    neg  = rs[WIDTH-1];
    zero = (rs == '0);
    case (o)
      OP_EQ:   return rs == rt;
      OP_NE:   return rs != rt;
      OP_LEZ:  return neg | zero;
      OP_GTZ:  return ~neg & ~zero;
      OP_LTZ:  return neg;
      OP_GEZ:  return ~neg;
      default: return 1'b0;
    endcase
  endfunction

  assign accept = bus.start & ~bus.flush &
                  ((state == ST_IDLE) || (state == ST_DONE));

  assign chunk_bits = rs_p0[idx*CHUNK +: CHUNK];

  popcnt_chunk #(.CHUNK(CHUNK), .OUT_W(PC_W)) u_popcnt (
    .bits  (chunk_bits),
    .count (chunk_cnt)
  );

  // Accumulator cannot wrap: its maximum is WIDTH, which CNT_W holds.
  assign acc_next = acc + CNT_W'(chunk_cnt);
  assign pop_cond = (op_p0 == OP_POP_EVEN) ? ~acc_next[0]
                                           : (acc_next >= thresh_p0);

  // Capture request operands on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= bus.op;
      rs_p0     <= bus.rs_val;
      thresh_p0 <= bus.thresh;
    end
  end

  // Control FSM with registered busy/done/cond/count; flush overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cond_q <= 1'b0;
      cnt_q  <= '0;
      acc    <= '0;
      idx    <= '0;
    end else if (bus.flush) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cond_q <= 1'b0;
      cnt_q  <= '0;
      acc    <= '0;
      idx    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
          if (bus.start) begin
            if (is_pop(bus.op)) begin
              state  <= ST_COUNT;
              busy_q <= 1'b1;
              acc    <= '0;
              idx    <= '0;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              cond_q <= cmp_eval(bus.op, bus.rs_val, bus.rt_val);
              cnt_q  <= '0;
            end
          end
        end
        ST_COUNT: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cond_q <= pop_cond;
            cnt_q  <= acc_next;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cond    = cond_q;
  assign bus.cnt_out = cnt_q;

endmodule
